// File: rtl/prime_power_exponentiator.sv
// prime_power_exponentiator
//   Computes result = a^(base^exponent) mod modulus, the Pollard p-1 accumulator step for one
//   prime base. Each of the exponent steps raises the accumulator to the power base using
//   left-to-right square-and-multiply over all 9 base bits. Each modular multiply is a
//   bit-serial interleaved shift-add-reduce that takes WIDTH cycles.
//
//   Optional feature macro: PPE_UNITY_EXIT_EN
//     defined   - stop as soon as the accumulator becomes 1 (1^x = 1)
//     undefined - always execute every exponent step
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   start_i     job request, sampled only in IDLE
//   a_in_i      value raised to the power (must be < modulus)
//   base_i      prime base p
//   exponent_i  repetition count e
//   modulus_i   modulus n (must be >= 2)
//   result_o    a^(p^e) mod n, valid from done and held afterwards
//   busy_o      high from the cycle after start is accepted until done, inclusive
//   done_o      one-cycle completion pulse (high while the FSM is in DONE)
//   err_o       illegal operands flag, updated with done and held like result_o

`timescale 1ns/1ps

module prime_power_exponentiator #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_in_i,
    input  logic [8:0]       base_i,
    input  logic [7:0]       exponent_i,
    input  logic [WIDTH-1:0] modulus_i,
    output logic [WIDTH-1:0] result_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] One = WIDTH'(1);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StSqr,
        StMul,
        StNext,
        StDone
    } state_e;

    state_e state_q, state_d;

    // Captured operands
    logic [WIDTH-1:0] a_q, a_d;
    logic [8:0]       base_q, base_d;
    logic [7:0]       exp_q, exp_d;
    logic [WIDTH-1:0] mod_q, mod_d;

    // Exponentiation state
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] t_q, t_d;
    logic [3:0]       k_q, k_d;
    logic [7:0]       step_q, step_d;

    // Modmul state: partial product and bit counter
    logic [WIDTH+1:0] p_q, p_d;
    logic [CntW-1:0]  cnt_q, cnt_d;

    // Held outputs
    logic [WIDTH-1:0] result_q, result_d;
    logic             err_q, err_d;

    // Combinational helpers
    logic             bad_ops;
    logic             mm_last;
    logic [7:0]       step_inc;
    logic [WIDTH+1:0] mod_ext;
    logic [WIDTH+1:0] y_ext;
    logic [WIDTH+1:0] p_dbl;
    logic [WIDTH+1:0] p_s1;
    logic [WIDTH+1:0] p_red;

    assign bad_ops  = (mod_q < WIDTH'(2)) || (a_q >= mod_q);
    assign mm_last  = (cnt_q == '0);
    assign step_inc = step_q + 8'd1;

    // One shift-add-reduce iteration. p < n and y < n, so 2p + y < 3n and two conditional
    // subtractions always bring it back below n.
    always_comb begin
        mod_ext = {2'b00, mod_q};
        y_ext   = (state_q == StMul) ? {2'b00, acc_q} : {2'b00, t_q};
        p_dbl   = {p_q[WIDTH:0], 1'b0} + (t_q[cnt_q] ? y_ext : '0);
        p_s1    = (p_dbl >= mod_ext) ? (p_dbl - mod_ext) : p_dbl;
        p_red   = (p_s1 >= mod_ext) ? (p_s1 - mod_ext) : p_s1;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (start_i) state_d = StLoad;
            end
            StLoad: begin
                if (bad_ops || (exp_q == 8'd0)) state_d = StDone;
                else                            state_d = StSqr;
            end
            StSqr: begin
                if (mm_last) begin
                    if (base_q[k_q])      state_d = StMul;
                    else if (k_q == 4'd0) state_d = StNext;
                    else                  state_d = StSqr;
                end
            end
            StMul: begin
                if (mm_last) begin
                    if (k_q == 4'd0) state_d = StNext;
                    else             state_d = StSqr;
                end
            end
            StNext: begin
                // step_inc cannot wrap: the job ends when it reaches exp_q (at most 255)
                if (step_inc == exp_q) state_d = StDone;
`ifdef PPE_UNITY_EXIT_EN
                else if (t_q == One)   state_d = StDone;
`endif
                else                   state_d = StSqr;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Datapath next-state logic
    always_comb begin
        a_d      = a_q;
        base_d   = base_q;
        exp_d    = exp_q;
        mod_d    = mod_q;
        acc_d    = acc_q;
        t_d      = t_q;
        k_d      = k_q;
        step_d   = step_q;
        p_d      = p_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        err_d    = err_q;

        case (state_q)
            StIdle: begin
                if (start_i) begin
                    a_d    = a_in_i;
                    base_d = base_i;
                    exp_d  = exponent_i;
                    mod_d  = modulus_i;
                end
            end
            StLoad: begin
                acc_d  = a_q;
                step_d = 8'd0;
                t_d    = One;
                k_d    = 4'd8;
                p_d    = '0;
                cnt_d  = CntMax;
                // Result and err are published on entry to DONE so they are valid with done
                if (state_d == StDone) begin
                    result_d = bad_ops ? '0 : a_q;
                    err_d    = bad_ops;
                end
            end
            StSqr, StMul: begin
                p_d   = p_red;
                cnt_d = cnt_q - 1'b1;
                if (mm_last) begin
                    t_d   = p_red[WIDTH-1:0];
                    p_d   = '0;
                    cnt_d = CntMax;
                    // Move to the next base bit only when another square follows
                    if (state_d == StSqr) k_d = k_q - 4'd1;
                end
            end
            StNext: begin
                acc_d  = t_q;
                step_d = step_inc;
                t_d    = One;
                k_d    = 4'd8;
                if (state_d == StDone) begin
                    result_d = t_q;
                    err_d    = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            base_q   <= '0;
            exp_q    <= '0;
            mod_q    <= '0;
            acc_q    <= '0;
            t_q      <= '0;
            k_q      <= '0;
            step_q   <= '0;
            p_q      <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            a_q      <= a_d;
            base_q   <= base_d;
            exp_q    <= exp_d;
            mod_q    <= mod_d;
            acc_q    <= acc_d;
            t_q      <= t_d;
            k_q      <= k_d;
            step_q   <= step_d;
            p_q      <= p_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

    // Outputs
    always_comb begin
        busy_o   = (state_q != StIdle);
        done_o   = (state_q == StDone);
        result_o = result_q;
        err_o    = err_q;
    end

endmodule

// File: tb/tb_prime_power_exponentiator.sv
// Self-checking bench for prime_power_exponentiator (WIDTH = 16).
// Cycle n of a job is the clock period that begins with the n-th rising edge counting the
// start-accepting edge as 1; done must be high exactly in cycle L and busy in cycles 1..L.

`timescale 1ns/1ps

module tb_prime_power_exponentiator;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] a_in;
    logic [8:0]  base;
    logic [7:0]  exponent;
    logic [15:0] modulus;
    logic [15:0] result;
    logic        busy;
    logic        done;
    logic        err;

    prime_power_exponentiator #(
        .WIDTH(16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (start),
        .a_in_i    (a_in),
        .base_i    (base),
        .exponent_i(exponent),
        .modulus_i (modulus),
        .result_o  (result),
        .busy_o    (busy),
        .done_o    (done),
        .err_o     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Expectations for the job in flight and for the held outputs
    bit          chk_en   = 1'b0;
    bit          in_job   = 1'b0;
    int          cyc      = 0;
    int          exp_L    = 0;
    logic [15:0] exp_res  = '0;
    logic        exp_err  = 1'b0;
    logic [15:0] held_res = '0;
    logic        held_err = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: a^(p^e) mod n by plain repeated multiplication, plus the latency formula
    function automatic void model(input longint unsigned a, input longint unsigned p,
                                  input longint unsigned e, input longint unsigned n,
                                  output logic [15:0] r, output logic er, output int lat);
        longint unsigned acc;
        longint unsigned x;
        int              s;
        if (n < 2 || a >= n) begin
            r = '0; er = 1'b1; lat = 2;
            return;
        end
        er = 1'b0;
        if (e == 0) begin
            r = a[15:0]; lat = 2;
            return;
        end
        acc = a;
        s   = 0;
        for (longint unsigned i = 0; i < e; i++) begin
            x = 1;
            for (longint unsigned j = 0; j < p; j++) x = (x * acc) % n;
            acc = x;
            s++;
`ifdef PPE_UNITY_EXIT_EN
            if (acc == 1) break;
`endif
        end
        r   = acc[15:0];
        lat = 2 + s * (1 + (9 + $countones(p[8:0])) * 16);
    endfunction

    // Single compare process: every cycle out of reset
    always @(negedge clk) begin
        if (rst_n && chk_en) begin
            if (in_job) begin
                cyc++;
                chk($sformatf("busy cyc%0d", cyc), {31'd0, busy}, 32'd1);
                chk($sformatf("done cyc%0d", cyc), {31'd0, done}, {31'd0, cyc == exp_L});
                if (cyc == exp_L) begin
                    chk("result", {16'd0, result}, {16'd0, exp_res});
                    chk("err", {31'd0, err}, {31'd0, exp_err});
                    held_res = exp_res;
                    held_err = exp_err;
                    in_job   = 1'b0;
                end
            end else begin
                chk("idle busy", {31'd0, busy}, 32'd0);
                chk("idle done", {31'd0, done}, 32'd0);
                chk("held result", {16'd0, result}, {16'd0, held_res});
                chk("held err", {31'd0, err}, {31'd0, held_err});
            end
        end
    end

    // Present operands with start, return just after the accepting edge with inputs scrambled
    task automatic issue(input logic [15:0] a, input logic [8:0] p, input logic [7:0] e,
                         input logic [15:0] n);
        @(negedge clk);
        a_in = a; base = p; exponent = e; modulus = n; start = 1'b1;
        @(posedge clk);
        model(a, p, e, n, exp_res, exp_err, exp_L);
        cyc    = 0;
        in_job = 1'b1;
        #1;
        start    = 1'b0;
        a_in     = 16'($urandom);
        base     = 9'($urandom);
        exponent = 8'($urandom);
        modulus  = 16'($urandom);
    endtask

    task automatic finish_job();
        int b;
        b = 0;
        while (in_job) begin
            @(negedge clk);
            b++;
            if (in_job && b > exp_L + 20) begin
                n_chk++;
                n_err++;
                $display("FAIL job timeout: got no completion, expected done at %0d", exp_L);
                in_job = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    task automatic run_job(input logic [15:0] a, input logic [8:0] p, input logic [7:0] e,
                           input logic [15:0] n);
        issue(a, p, e, n);
        finish_job();
    endtask

    // Pin the model to hand-computed values before trusting it
    task automatic pin(input string name, input logic [15:0] a, input logic [8:0] p,
                       input logic [7:0] e, input logic [15:0] n, input logic [15:0] r_req,
                       input logic er_req, input int l_req);
        logic [15:0] r;
        logic        er;
        int          l;
        model(a, p, e, n, r, er, l);
        chk({"pin res ", name}, {16'd0, r}, {16'd0, r_req});
        chk({"pin err ", name}, {31'd0, er}, {31'd0, er_req});
        chk({"pin lat ", name}, l, l_req);
    endtask

    initial begin
        logic [15:0] ra;
        logic [15:0] rn;
        int          ln;

        rst_n = 1'b0; start = 1'b0;
        a_in = '0; base = '0; exponent = '0; modulus = '0;

        pin("t1", 16'd2, 9'd2, 8'd3, 16'd1000, 16'd256, 1'b0, 485);
        pin("t2", 16'd3, 9'd5, 8'd2, 16'd101, 16'd10, 1'b0, 356);
        pin("t3", 16'd7, 9'd3, 8'd0, 16'd11, 16'd7, 1'b0, 2);
        pin("t4", 16'd20, 9'd3, 8'd2, 16'd11, 16'd0, 1'b1, 2);
`ifdef PPE_UNITY_EXIT_EN
        pin("t6", 16'd1, 9'd3, 8'd4, 16'd97, 16'd1, 1'b0, 179);
`else
        pin("t6", 16'd1, 9'd3, 8'd4, 16'd97, 16'd1, 1'b0, 710);
`endif

        repeat (3) @(negedge clk);
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset done", {31'd0, done}, 32'd0);
        chk("reset result", {16'd0, result}, 32'd0);
        chk("reset err", {31'd0, err}, 32'd0);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // Directed cases
        run_job(16'd2, 9'd2, 8'd3, 16'd1000);
        run_job(16'd3, 9'd5, 8'd2, 16'd101);
        run_job(16'd7, 9'd3, 8'd0, 16'd11);
        run_job(16'd5, 9'd0, 8'd4, 16'd11);
        run_job(16'd9, 9'd1, 8'd3, 16'd11);
        run_job(16'd0, 9'd3, 8'd2, 16'd1);
        run_job(16'd20, 9'd3, 8'd2, 16'd11);
        run_job(16'd4, 9'd7, 8'd1, 16'd13);
        run_job(16'd1, 9'd3, 8'd4, 16'd97);

        // Extra start pulse mid-job with different operands must be ignored
        issue(16'd6, 9'd3, 8'd2, 16'd1009);
        repeat (40) @(negedge clk);
        start = 1'b1; a_in = 16'd2; base = 9'd2; exponent = 8'd1; modulus = 16'd7;
        @(negedge clk);
        start = 1'b0;
        finish_job();

        // Start during the done cycle must be ignored
        issue(16'd3, 9'd5, 8'd2, 16'd101);
        repeat (exp_L - 1) @(posedge clk);
        #2;
        start = 1'b1; a_in = 16'd2; base = 9'd2; exponent = 8'd1; modulus = 16'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        finish_job();
        repeat (3) @(negedge clk);

        // Asynchronous reset in the middle of a job
        issue(16'd11, 9'd13, 8'd2, 16'd4093);
        repeat (30) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midrst busy", {31'd0, busy}, 32'd0);
        chk("midrst done", {31'd0, done}, 32'd0);
        chk("midrst result", {16'd0, result}, 32'd0);
        chk("midrst err", {31'd0, err}, 32'd0);
        in_job   = 1'b0;
        held_res = '0;
        held_err = 1'b0;
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        run_job(16'd2, 9'd2, 8'd3, 16'd1000);

        // Largest exponent: step counter must reach 255 without wrapping
        run_job(16'd5, 9'd0, 8'd255, 16'd11);

        // Randomized jobs
        for (int i = 0; i < 24; i++) begin
            if (i % 8 == 7)      rn = 16'($urandom_range(0, 1));
            else if (i % 4 == 0) rn = 16'($urandom_range(2, 20));
            else                 rn = 16'($urandom_range(2, 65535));
            ln = (rn == 0) ? 0 : int'(rn) - 1;
            if ($urandom_range(0, 7) == 0) ra = 16'($urandom_range(0, 65535));
            else                           ra = 16'($urandom_range(0, ln));
            run_job(ra, 9'($urandom_range(0, 511)), 8'($urandom_range(0, 4)), rn);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
